// File: rtl/score_bcd_counter.sv
// score_bcd_counter: BCD score, combo and multiplier tracker for a digit display.
// Optional build macro SCORE_LEADING_BLANK_EN blanks leading zero digits (4'hF).
module score_bcd_counter #(
  parameter int NUM_DIGITS = 4,
  parameter int COMBO_STEP = 10,
  parameter int MAX_MULT   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    hit,
  input  logic                    miss,
  input  logic                    clear,
  output logic [4*NUM_DIGITS-1:0] score_bcd,
  output logic [7:0]              combo_bcd,
  output logic [3:0]              mult_bcd,
  output logic                    score_sat
);

  typedef logic [NUM_DIGITS-1:0][3:0] digits_t;

  localparam logic [3:0] STEP_LAST = 4'(COMBO_STEP - 1);
  localparam logic [3:0] MULT_TOP  = 4'(MAX_MULT);

  // Display value of a zero score, as shown right after reset/clear.
  function automatic digits_t zero_disp();
    digits_t v;
    v = '0;
`ifdef SCORE_LEADING_BLANK_EN
    for (int i = 1; i < NUM_DIGITS; i++) begin
      v[i] = 4'hF;
    end
`endif
    return v;
  endfunction

  localparam digits_t SCORE_RST = zero_disp();
`ifdef SCORE_LEADING_BLANK_EN
  localparam logic [7:0] COMBO_RST = 8'hF0;
`else
  localparam logic [7:0] COMBO_RST = 8'h00;
`endif

  digits_t    score_q;
  digits_t    score_d;
  digits_t    score_add;
  digits_t    score_disp;
  logic       add_cout;
  logic [3:0] add_in;
  logic [4:0] dsum;

  logic [7:0] combo_q;
  logic [7:0] combo_d;
  logic [7:0] combo_inc;
  logic [7:0] combo_disp;

  logic [3:0] step_q;
  logic [3:0] step_d;
  logic [3:0] step_inc;

  logic [3:0] mult_q;
  logic [3:0] mult_d;
  logic [3:0] mult_inc;

  logic       sat_q;
  logic       sat_d;

  // Ripple BCD add of the current multiplier into the score.
  always_comb begin
    score_add = '0;
    add_in    = mult_q;
    dsum      = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      dsum = {1'b0, score_q[i]} + {1'b0, add_in};
      if (dsum > 5'd9) begin
        score_add[i] = 4'(dsum - 5'd10);
        add_in       = 4'd1;
      end else begin
        score_add[i] = dsum[3:0];
        add_in       = 4'd0;
      end
    end
    add_cout = (add_in != 4'd0);
  end

  // Two-digit BCD combo increment, sticking at 99.
  always_comb begin
    combo_inc = combo_q;
    if (combo_q != 8'h99) begin
      if (combo_q[3:0] == 4'd9) begin
        combo_inc = {combo_q[7:4] + 4'd1, 4'd0};
      end else begin
        combo_inc = {combo_q[7:4], combo_q[3:0] + 4'd1};
      end
    end
  end

  // Step counter wraps every COMBO_STEP hits and bumps the multiplier.
  always_comb begin
    step_inc = step_q + 4'd1;
    mult_inc = mult_q;
    if (step_q == STEP_LAST) begin
      step_inc = 4'd0;
      if (mult_q < MULT_TOP) begin
        mult_inc = mult_q + 4'd1;
      end
    end
  end

  // Next state: clear beats miss beats hit; otherwise hold.
  always_comb begin
    score_d = score_q;
    combo_d = combo_q;
    step_d  = step_q;
    mult_d  = mult_q;
    sat_d   = sat_q;
    if (clear) begin
      score_d = '0;
      combo_d = 8'h00;
      step_d  = 4'd0;
      mult_d  = 4'd1;
      sat_d   = 1'b0;
    end else if (miss) begin
      combo_d = 8'h00;
      step_d  = 4'd0;
      mult_d  = 4'd1;
    end else if (hit) begin
      combo_d = combo_inc;
      step_d  = step_inc;
      mult_d  = mult_inc;
      if (!sat_q) begin
        if (add_cout) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            score_d[i] = 4'd9;
          end
          sat_d = 1'b1;
        end else begin
          score_d = score_add;
        end
      end
    end
  end

  // Display form of the next state; blanking never touches internal state.
  always_comb begin
    score_disp = score_d;
    combo_disp = combo_d;
`ifdef SCORE_LEADING_BLANK_EN
    begin : blank
      logic seen;
      seen = 1'b0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
        if (score_d[i] != 4'd0) begin
          seen = 1'b1;
        end
        if (!seen) begin
          score_disp[i] = 4'hF;
        end
      end
    end
    if (combo_d[7:4] == 4'd0) begin
      combo_disp[7:4] = 4'hF;
    end
`endif
  end

  // Internal counter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
      combo_q <= 8'h00;
      step_q  <= 4'd0;
      mult_q  <= 4'd1;
      sat_q   <= 1'b0;
    end else begin
      score_q <= score_d;
      combo_q <= combo_d;
      step_q  <= step_d;
      mult_q  <= mult_d;
      sat_q   <= sat_d;
    end
  end

  // Registered display outputs, updated alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_bcd <= SCORE_RST;
      combo_bcd <= COMBO_RST;
      mult_bcd  <= 4'd1;
      score_sat <= 1'b0;
    end else begin
      score_bcd <= score_disp;
      combo_bcd <= combo_disp;
      mult_bcd  <= mult_d;
      score_sat <= sat_d;
    end
  end

endmodule

// File: tb/tb_score_bcd_counter.sv
// tb_score_bcd_counter: directed checks of score_bcd_counter at default params.
// Honours SCORE_LEADING_BLANK_EN when the RTL is built with it.
module tb_score_bcd_counter;

  logic        clk;
  logic        reset;
  logic        hit;
  logic        miss;
  logic        clear;
  logic [15:0] score_bcd;
  logic [7:0]  combo_bcd;
  logic [3:0]  mult_bcd;
  logic        score_sat;

  int n_cmp;
  int n_err;
  logic [28:0] obs;
  logic [28:0] exp;

  score_bcd_counter #(
    .NUM_DIGITS(4),
    .COMBO_STEP(10),
    .MAX_MULT(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .hit(hit),
    .miss(miss),
    .clear(clear),
    .score_bcd(score_bcd),
    .combo_bcd(combo_bcd),
    .mult_bcd(mult_bcd),
    .score_sat(score_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] ds(input logic [15:0] v);
`ifdef SCORE_LEADING_BLANK_EN
    if (v[15:4] == 12'h0) return {12'hFFF, v[3:0]};
    if (v[15:8] == 8'h0) return {8'hFF, v[7:0]};
    if (v[15:12] == 4'h0) return {4'hF, v[11:0]};
`endif
    return v;
  endfunction

  function automatic logic [7:0] dc(input logic [7:0] v);
`ifdef SCORE_LEADING_BLANK_EN
    if (v[7:4] == 4'h0) return {4'hF, v[3:0]};
`endif
    return v;
  endfunction

  task automatic drive(input logic h, input logic m,
                       input logic c, input int n);
    @(negedge clk);
    hit = h;
    miss = m;
    clear = c;
    repeat (n) @(negedge clk);
    hit = 1'b0;
    miss = 1'b0;
    clear = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0000), dc(8'h00), 4'd1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_held: got %h want %h", obs, exp);
    end
    reset = 1'b0;
    @(negedge clk);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_hits();
    do_reset();
    drive(1, 0, 0, 3);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0003), dc(8'h03), 4'd1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL three_hits: got %h want %h", obs, exp);
    end
    repeat (3) @(negedge clk);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL idle_hold: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_multiplier();
    do_reset();
    drive(1, 0, 0, 10);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0010), dc(8'h10), 4'd2, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL ten_hits: got %h want %h", obs, exp);
    end
    drive(1, 0, 0, 1);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0012), dc(8'h11), 4'd2, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL eleventh_hit: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_mult_ceiling();
    do_reset();
    drive(1, 0, 0, 40);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0100), dc(8'h40), 4'd4, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL hits_40: got %h want %h", obs, exp);
    end
    drive(1, 0, 0, 59);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0336), dc(8'h99), 4'd4, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL hits_99: got %h want %h", obs, exp);
    end
    drive(1, 0, 0, 1);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0340), dc(8'h99), 4'd4, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL combo_sat_100: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_miss();
    do_reset();
    drive(1, 0, 0, 25);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0045), dc(8'h25), 4'd3, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL hits_25: got %h want %h", obs, exp);
    end
    drive(0, 1, 0, 1);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0045), dc(8'h00), 4'd1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL miss: got %h want %h", obs, exp);
    end
    drive(1, 1, 0, 1);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL hit_and_miss: got %h want %h", obs, exp);
    end
    drive(1, 0, 0, 10);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0055), dc(8'h10), 4'd2, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL step_after_miss: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    drive(1, 0, 0, 2514);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h9996), dc(8'h99), 4'd4, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL near_sat: got %h want %h", obs, exp);
    end
    drive(1, 0, 0, 1);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h9999), dc(8'h99), 4'd4, 1'b1};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL sat_enter: got %h want %h", obs, exp);
    end
    drive(1, 0, 0, 5);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL sat_hold: got %h want %h", obs, exp);
    end
    drive(1, 0, 1, 1);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0000), dc(8'h00), 4'd1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL clear: got %h want %h", obs, exp);
    end
    drive(1, 0, 0, 1);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0001), dc(8'h01), 4'd1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL hit_after_clear: got %h want %h", obs, exp);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 0, 0, 12);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0014), dc(8'h12), 4'd2, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL pre_async: got %h want %h", obs, exp);
    end
    #2;
    reset = 1'b1;
    #1;
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {ds(16'h0000), dc(8'h00), 4'd1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL async_reset: got %h want %h", obs, exp);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

`ifdef SCORE_LEADING_BLANK_EN
  task automatic test_blank();
    do_reset();
    drive(1, 0, 0, 24);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {16'hFF42, 8'h24, 4'd3, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL blank_42: got %h want %h", obs, exp);
    end
    drive(0, 1, 0, 1);
    drive(1, 0, 0, 5);
    obs = {score_bcd, combo_bcd, mult_bcd, score_sat};
    exp = {16'hFF47, 8'hF5, 4'd1, 1'b0};
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL blank_combo5: got %h want %h", obs, exp);
    end
  endtask
`endif

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    hit = 1'b0;
    miss = 1'b0;
    clear = 1'b0;
    test_reset();
    test_hits();
    test_multiplier();
    test_mult_ceiling();
    test_miss();
    test_saturation();
    test_async_reset();
`ifdef SCORE_LEADING_BLANK_EN
    test_blank();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
